// File: rtl/tri_fifo.sv
// Show-ahead triangle FIFO between projection and rasterizer, cleared by Reset or flush.
// Define TRI_FIFO_STATS_EN to add the max_count / drop_count statistics ports.
module tri_fifo #(
   parameter int DEPTH    = 32,
   parameter int AW       = 5,
   parameter int AF_LEVEL = 28
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [2:0][1:0][9:0]  wr_data,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [2:0][1:0][9:0]  rd_data,
   output logic                  empty,
   output logic [AW:0]           count,
   output logic                  overflow,
   output logic                  underflow
`ifdef TRI_FIFO_STATS_EN
   ,
   output logic [AW:0]           max_count,
   output logic [15:0]           drop_count
`endif
);

   typedef logic [2:0][1:0][9:0] tri_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);

   tri_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          clr, wr_ok, rd_ok;

   assign clr = Reset | flush;

   // Status flags decode only registered state, so no strobe reaches an output.
   assign full        = (count_q == DEPTH_C);
   assign empty       = (count_q == '0);
   assign almost_full = (count_q >= AF_C);
   assign count       = count_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;
   assign rd_data     = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
   assign wr_ok = wr_en & (~full | rd_en);
   assign rd_ok = rd_en & ~empty;

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      if (wr_en && !wr_ok) ovf_d = 1'b1;
      if (rd_en && empty)  unf_d = 1'b1;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
   end

   // NOTE: storage is deliberately not reset; only the pointers and count define valid contents.
   always_ff @(posedge Clk) begin
      if (wr_ok && !clr) mem_q[wr_ptr_q] <= wr_data;
   end

`ifdef TRI_FIFO_STATS_EN
   logic [AW:0] max_count_q;
   logic [15:0] drop_count_q;

   always_ff @(posedge Clk) begin
      if (clr) begin
         max_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         if (count_d > max_count_q) max_count_q <= count_d;
         if (wr_en && !wr_ok && drop_count_q != 16'hFFFF)
            drop_count_q <= drop_count_q + 16'd1;
      end
   end

   assign max_count  = max_count_q;
   assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_tri_fifo.sv
// Self-checking bench for tri_fifo: queue-based reference model checked every cycle plus directed literals.
module tb_tri_fifo;

   localparam int DEPTH    = 32;
   localparam int AW       = 5;
   localparam int AF_LEVEL = 28;

   typedef logic [2:0][1:0][9:0] tri_t;

   logic        Clk = 1'b0;
   logic        Reset, flush, wr_en, rd_en;
   tri_t        wr_data, rd_data;
   logic        full, almost_full, empty, overflow, underflow;
   logic [AW:0] count;
`ifdef TRI_FIFO_STATS_EN
   logic [AW:0] max_count;
   logic [15:0] drop_count;
`endif

   always #5 Clk = ~Clk;

   tri_fifo #(.DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF_LEVEL)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .flush       (flush),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .almost_full (almost_full),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
`ifdef TRI_FIFO_STATS_EN
      ,
      .max_count   (max_count),
      .drop_count  (drop_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic tri_t mk_tri(input int i);
      tri_t       t;
      logic [9:0] x, y;
      x = 10'(10 * i);
      y = 10'(5 * i);
      for (int v = 0; v < 3; v++) begin
         t[v][0] = x;
         t[v][1] = y;
      end
      return t;
   endfunction

   // Reference model: an ordered queue of stored triangles plus sticky flags.
   tri_t mq[$];
   bit   m_ovf, m_unf;
   int   m_max, m_drop;
   bit   chk_en = 1'b0;

   always @(posedge Clk) begin : model
      int  n;
      bit  do_wr, do_rd;
      n = mq.size();
      if (Reset || flush) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_max  = 0;
         m_drop = 0;
      end else begin
         do_rd = rd_en && (n > 0);
         do_wr = wr_en && ((n < DEPTH) || rd_en);
         if (rd_en && n == 0) m_unf = 1'b1;
         if (wr_en && !do_wr) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
         end
         if (do_rd) void'(mq.pop_front());
         if (do_wr) mq.push_back(wr_data);
         if (mq.size() > m_max) m_max = mq.size();
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         check("count",       count,       mq.size());
         check("empty",       empty,       mq.size() == 0);
         check("full",        full,        mq.size() == DEPTH);
         check("almost_full", almost_full, mq.size() >= AF_LEVEL);
         check("overflow",    overflow,    m_ovf);
         check("underflow",   underflow,   m_unf);
         if (mq.size() > 0) check("rd_data", rd_data, mq[0]);
`ifdef TRI_FIFO_STATS_EN
         check("max_count",  max_count,  m_max);
         check("drop_count", drop_count, m_drop);
`endif
      end
   end

   task automatic cyc(input logic we, input tri_t wd, input logic re, input logic fl);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      flush   = fl;
      @(posedge Clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      Reset   = 1'b1;
      flush   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;
      @(posedge Clk);
      @(posedge Clk);
      #1;
      chk_en = 1'b1;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full",  full, 0);
      check("rst_af",    almost_full, 0);
      check("rst_ovf",   overflow, 0);
      check("rst_unf",   underflow, 0);
      Reset = 1'b0;

      // T0..T3 written back to back; head visible one cycle after the first write.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, mk_tri(i), 1'b0, 1'b0);
         if (i == 0) begin
            check("first_empty", empty, 0);
            check("first_data",  rd_data, mk_tri(0));
         end
      end
      check("cnt4", count, 4);

      for (int i = 0; i < 4; i++) begin
         if (i == 1) check("lit_T1", rd_data, {3{10'd5, 10'd10}});
         check("pop_order", rd_data, mk_tri(i));
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
      check("drained_empty", empty, 1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("unf_set",   underflow, 1);
      check("unf_count", count, 0);

      // Overfill: 33 writes, last one dropped.
      Reset = 1'b1;
      cyc(1'b0, '0, 1'b0, 1'b0);
      Reset = 1'b0;
      check("unf_cleared", underflow, 0);
      for (int i = 0; i < 33; i++) begin
         cyc(1'b1, mk_tri(i), 1'b0, 1'b0);
         if (i == 26) check("af_27", almost_full, 0);
         if (i == 27) check("af_28", almost_full, 1);
         if (i == 31) check("full_32", full, 1);
      end
      check("ovf_set",   overflow, 1);
      check("ovf_count", count, 32);
`ifdef TRI_FIFO_STATS_EN
      check("lit_drop", drop_count, 1);
      check("lit_max",  max_count, 32);
`endif
      for (int i = 0; i < 32; i++) begin
         check("drain_order", rd_data, mk_tri(i));
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
      check("drain_empty", empty, 1);

      // Almost-full threshold, then fill to full and run simultaneous push/pop at full.
      cyc(1'b0, '0, 1'b0, 1'b1);
      check("flush_ovf", overflow, 0);
      for (int i = 0; i < 28; i++) cyc(1'b1, mk_tri(50 + i), 1'b0, 1'b0);
      check("af_on", almost_full, 1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("af_off", almost_full, 0);
      check("cnt27",  count, 27);
      for (int i = 0; i < 5; i++) cyc(1'b1, mk_tri(80 + i), 1'b0, 1'b0);
      check("full_again", full, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, mk_tri(90 + i), 1'b1, 1'b0);
         check("both_full_cnt", count, 32);
         check("both_full",     full, 1);
      end
      check("ovf_none", overflow, 0);

      for (int i = 0; i < 100; i++)
         cyc(1'($urandom_range(0, 1)), tri_t'({$urandom, $urandom}),
             1'($urandom_range(0, 1)), 1'b0);
      repeat (40) cyc(1'b0, '0, 1'b1, 1'b0);
      check("rand_drained", empty, 1);

      // Reset in the middle of traffic behaves like flush.
      for (int i = 0; i < 6; i++) cyc(1'b1, mk_tri(20 + i), 1'b0, 1'b0);
      Reset = 1'b1;
      cyc(1'b1, mk_tri(99), 1'b1, 1'b0);
      Reset = 1'b0;
      check("midrst_count", count, 0);
      check("midrst_empty", empty, 1);

      // Flush wins over a same-cycle write; next write shows up one cycle later.
      for (int i = 0; i < 5; i++) cyc(1'b1, mk_tri(30 + i), 1'b0, 1'b0);
      cyc(1'b1, mk_tri(77), 1'b0, 1'b1);
      check("flush_count", count, 0);
      check("flush_empty", empty, 1);
      check("flush_ovf2",  overflow, 0);
      cyc(1'b1, mk_tri(42), 1'b0, 1'b0);
      check("post_flush_empty", empty, 0);
      check("post_flush_data",  rd_data, {3{10'd210, 10'd420}});

      @(negedge Clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tri_fifo.md
Name: tri_fifo

Overview:
- Triangle FIFO between the projection stage and the rasterizer.
- Buffers projected screen-space triangles (3 vertices × x,y × 10 bits) written on a one-cycle write strobe.
- Presents the head entry show-ahead (first-word-fall-through) to the rasterizer, which pops it with a read strobe.
- Flushed once per frame before projection starts.

Parameters:
- DEPTH, 32, number of triangle entries; power of two, ≥4.
- AW, 5, address width; must equal log2(DEPTH).
- AF_LEVEL, 28, count at or above which almost_full is asserted.

Ports:
- Clk  input  1  clock.
- Reset  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of contents and status; one-cycle pulse.
- wr_en  input  1  write strobe from projection stage (one cycle per triangle).
- wr_data  input  [2:0][1:0][9:0]  projected triangle: vertex, {y,x}, 10-bit coordinate.
- full  output  1  high when count == DEPTH.
- almost_full  output  1  high when count >= AF_LEVEL.
- rd_en  input  1  pop strobe from rasterizer.
- rd_data  output  [2:0][1:0][9:0]  head entry; valid whenever empty is low.
- empty  output  1  high when count == 0.
- count  output  [AW:0]  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky: a write was dropped because the FIFO was full.
- underflow  output  1  sticky: rd_en was asserted while empty.

Behaviour:
- State: wr_ptr, rd_ptr (AW bits, wrap modulo DEPTH), count (AW+1 bits), storage array, sticky flags.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - Storage contents are don't-care after reset.
  - rd_data is don't-care while empty.
- Flags (full, empty, almost_full) are decoded from the registered count. No combinational path from wr_en or rd_en to any output.
- Write accepted when wr_en=1 and (full=0, or rd_en=1 in the same cycle):
  - storage[wr_ptr] <= wr_data;
  - wr_ptr <= wr_ptr+1, wrapping DEPTH-1 to 0.
- Read accepted when rd_en=1 and empty=0: rd_ptr <= rd_ptr+1, with wrap.
- rd_data = storage[rd_ptr], combinational from registered pointer and storage.
- Latency:
  - A write accepted on edge E into an empty FIFO gives empty=0 and rd_data = that entry in the cycle after E.
  - After a pop on edge E, the next entry appears in the cycle after E.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither.
- Boundary conditions:
  - Full, wr_en=1, rd_en=0: write dropped, no state change except overflow <= 1.
  - Full, wr_en=1, rd_en=1: both accepted, count stays DEPTH, full stays 1.
  - Empty, rd_en=1, wr_en=0: read ignored, underflow <= 1.
  - Empty, rd_en=1, wr_en=1: write accepted, read ignored, underflow <= 1; count becomes 1.
- Pointer wrap is exact. Entry order is preserved across any number of wraps.
- flush=1: pointers <= 0, count <= 0, overflow <= 0, underflow <= 0. Flush beats wr_en/rd_en in the same cycle; a write in that cycle is discarded.
- Reset asserted mid-stream: identical to flush. All buffered triangles are lost, and no output glitches beyond the next edge.
- Sticky flags clear only on Reset or flush.

Optional Feature:
- Macro TRI_FIFO_STATS_EN.
- Defined: adds output max_count [AW:0] and output drop_count [15:0].
  - max_count: high-water mark of count since the last Reset/flush.
  - drop_count: counts dropped writes, saturating at 16'hFFFF.
  - Both reset to 0 on Reset or flush.
- Not defined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, then write triangles T0..T3 (x=10*i, y=5*i) on consecutive cycles, rd_en=0 -> count=4, empty=0, rd_data=T0 one cycle after the first write.
- Pop 4 times -> rd_data sequence T0,T1,T2,T3; empty=1 after the 4th pop; then rd_en once more -> underflow=1, count stays 0.
- DEPTH=32: write 33 triangles with no reads -> full=1 at count 32; 33rd dropped; overflow=1; drain returns exactly entries 0..31; with STATS: drop_count=1, max_count=32.
- Write 28 entries -> almost_full=1 at count 28, =0 after one pop (count 27).
- Fill to full, then assert wr_en and rd_en together for 3 cycles -> count stays 32; output order continues past wrap without loss; 100 interleaved random ops check order against a scoreboard model.
- Write 5 entries, then flush with wr_en=1 in the same cycle -> count=0, empty=1, overflow=0; the next write W appears as rd_data after one cycle.
